// File: rtl/uart_rx_deframer.sv
// uart_rx_deframer: 16x-oversampled UART receiver with a valid/ready byte output.
// Frame is 8N1 by default; define UART_RX_PARITY_EN for 8E1 (even parity checked).
module uart_rx_deframer #(
  parameter int BAUD_DIV = 54,
  parameter int OVS = 16
) (
  input  logic       CLK100MHZ,
  input  logic       fpga_rst,
  input  logic       serial_in,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);
  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] START = 3'd1;
  localparam logic [2:0] DATA  = 3'd2;
  localparam logic [2:0] STOP  = 3'd3;
  localparam logic [2:0] BRK   = 3'd4;
`ifdef UART_RX_PARITY_EN
  localparam logic [2:0] PARITY = 3'd5;
  logic par_bit;
`endif
  logic [1:0] rst_q;
  logic rst_i;
  logic [2:0] state;
  logic [1:0] sync;
  logic [15:0] div_cnt;
  logic [3:0] ovs_cnt;
  logic [2:0] bit_cnt;
  logic [7:0] shift;
  logic done, rx_s, tick, mid, last, stop_ok;
  // Reset asserts immediately but releases synchronously to the clock.
  always_ff @(posedge CLK100MHZ or posedge fpga_rst)
    if (fpga_rst) rst_q <= 2'b11;
    else rst_q <= {rst_q[0], 1'b0};
  assign rst_i = rst_q[1];
  assign rx_s = sync[1];
  assign tick = div_cnt == 16'(BAUD_DIV - 1);
  assign mid = tick && ovs_cnt == 4'(OVS / 2 - 1);
  assign last = tick && ovs_cnt == 4'(OVS - 1);
  assign busy = state != IDLE;
`ifdef UART_RX_PARITY_EN
  assign stop_ok = rx_s && !(^shift ^ par_bit);
`else
  assign stop_ok = rx_s;
`endif
  always_ff @(posedge CLK100MHZ or posedge rst_i)
    if (rst_i) begin
      state <= IDLE;
      sync <= 2'b11;
      div_cnt <= '0;
      ovs_cnt <= '0;
      bit_cnt <= '0;
      shift <= '0;
      done <= 1'b0;
      rx_data <= '0;
      rx_valid <= 1'b0;
      frame_err <= 1'b0;
      overrun <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit <= 1'b0;
`endif
    end else begin
      sync <= {sync[0], serial_in};
      frame_err <= 1'b0;
      overrun <= 1'b0;
      done <= 1'b0;
      div_cnt <= (state == IDLE || tick) ? '0 : div_cnt + 16'd1;
      ovs_cnt <= (state == IDLE || (state == START && mid)) ? '0 : tick ? ovs_cnt + 4'd1 : ovs_cnt;
      // A completion arriving with a full, unaccepted holding register is dropped.
      if (done) begin
        if (rx_valid && !rx_ready) overrun <= 1'b1;
        else begin
          rx_data <= shift;
          rx_valid <= 1'b1;
        end
      end else if (rx_valid && rx_ready) rx_valid <= 1'b0;
      case (state)
        IDLE:  if (!rx_s) state <= START;
        START: if (mid) begin
          state <= rx_s ? IDLE : DATA;
          bit_cnt <= '0;
        end
        DATA:  if (last) begin
          shift <= {rx_s, shift[7:1]};
          bit_cnt <= bit_cnt + 3'd1;
`ifdef UART_RX_PARITY_EN
          if (bit_cnt == 3'd7) state <= PARITY;
`else
          if (bit_cnt == 3'd7) state <= STOP;
`endif
        end
`ifdef UART_RX_PARITY_EN
        PARITY: if (last) begin
          par_bit <= rx_s;
          state <= STOP;
        end
`endif
        STOP:  if (last) begin
          done <= stop_ok;
          frame_err <= !stop_ok;
          state <= (stop_ok || rx_s) ? IDLE : BRK;
        end
        BRK:   if (rx_s) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_uart_rx_deframer.sv
// tb_uart_rx_deframer: randomized, self-checking bench for uart_rx_deframer (BAUD_DIV=4).
// Build with UART_RX_PARITY_EN defined to exercise the 8E1 variant.
module tb_uart_rx_deframer;
  localparam int BIT = 64;
  logic clk = 0, rst = 0, serial_in = 1, rx_ready = 0;
  logic [7:0] rx_data;
  logic rx_valid, frame_err, overrun, busy;
  int n_checks = 0, n_fail = 0;
  int fe_cnt = 0, ov_cnt = 0;
  bit busy_seen = 0;
  logic [7:0] got_q[$];

  uart_rx_deframer #(.BAUD_DIV(4)) dut (
    .CLK100MHZ(clk), .fpga_rst(rst), .serial_in(serial_in), .rx_data(rx_data),
    .rx_valid(rx_valid), .rx_ready(rx_ready), .frame_err(frame_err),
    .overrun(overrun), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk)
    if (!rst) begin
      if (rx_valid && rx_ready) got_q.push_back(rx_data);
      if (frame_err) fe_cnt++;
      if (overrun) ov_cnt++;
      if (busy) busy_seen = 1;
    end

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic clear_obs();
    got_q.delete();
    fe_cnt = 0;
    ov_cnt = 0;
    busy_seen = 0;
  endtask

  task automatic send_frame(input logic [7:0] d, input bit stop, input bit par_flip);
    serial_in = 0;
    wait_clk(BIT);
    for (int i = 0; i < 8; i++) begin
      serial_in = d[i];
      wait_clk(BIT);
    end
`ifdef UART_RX_PARITY_EN
    serial_in = ^d ^ par_flip;
    wait_clk(BIT);
`endif
    serial_in = stop;
    wait_clk(BIT);
  endtask

  task automatic test_reset();
    rst = 1;
    wait_clk(3);
    rst = 0;
    wait_clk(5);
    n_checks++; if (rx_data !== 8'h00) begin n_fail++; $display("FAIL reset_data got=%h exp=00", rx_data); end
    n_checks++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", rx_valid); end
    n_checks++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_ferr got=%b exp=0", frame_err); end
    n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL reset_ovr got=%b exp=0", overrun); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
  endtask

  task automatic test_back_to_back();
    clear_obs();
    rx_ready = 1;
    send_frame(8'h55, 1, 0);
    send_frame(8'hA3, 1, 0);
    wait_clk(20);
    n_checks++; if (got_q.size() !== 2) begin n_fail++; $display("FAIL b2b_count got=%0d exp=2", got_q.size()); end
    n_checks++; if (got_q.size() > 0 && got_q[0] !== 8'h55) begin n_fail++; $display("FAIL b2b_first got=%h exp=55", got_q[0]); end
    n_checks++; if (got_q.size() > 1 && got_q[1] !== 8'hA3) begin n_fail++; $display("FAIL b2b_second got=%h exp=a3", got_q[1]); end
    n_checks++; if (fe_cnt !== 0) begin n_fail++; $display("FAIL b2b_ferr got=%0d exp=0", fe_cnt); end
    n_checks++; if (ov_cnt !== 0) begin n_fail++; $display("FAIL b2b_ovr got=%0d exp=0", ov_cnt); end
  endtask

  task automatic test_false_start();
    clear_obs();
    serial_in = 0;
    wait_clk(20);
    serial_in = 1;
    wait_clk(60);
    n_checks++; if (busy_seen !== 1'b1) begin n_fail++; $display("FAIL fs_busy_seen got=%b exp=1", busy_seen); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL fs_busy_end got=%b exp=0", busy); end
    n_checks++; if (got_q.size() !== 0) begin n_fail++; $display("FAIL fs_valid got=%0d exp=0", got_q.size()); end
    n_checks++; if (fe_cnt !== 0) begin n_fail++; $display("FAIL fs_ferr got=%0d exp=0", fe_cnt); end
  endtask

  task automatic test_break();
    clear_obs();
    send_frame(8'h3C, 0, 0);
    wait_clk(300);
    n_checks++; if (fe_cnt !== 1) begin n_fail++; $display("FAIL brk_ferr got=%0d exp=1", fe_cnt); end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL brk_hold_busy got=%b exp=1", busy); end
    n_checks++; if (got_q.size() !== 0) begin n_fail++; $display("FAIL brk_nodata got=%0d exp=0", got_q.size()); end
    serial_in = 1;
    wait_clk(10);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL brk_release got=%b exp=0", busy); end
    send_frame(8'h81, 1, 0);
    wait_clk(20);
    n_checks++; if (got_q.size() !== 1 || got_q[0] !== 8'h81) begin n_fail++; $display("FAIL brk_next got_n=%0d exp=1 byte %h", got_q.size(), 8'h81); end
    n_checks++; if (fe_cnt !== 1) begin n_fail++; $display("FAIL brk_ferr_after got=%0d exp=1", fe_cnt); end
  endtask

  task automatic test_overrun();
    clear_obs();
    rx_ready = 0;
    send_frame(8'h11, 1, 0);
    send_frame(8'h22, 1, 0);
    wait_clk(20);
    n_checks++; if (rx_valid !== 1'b1) begin n_fail++; $display("FAIL ovr_valid got=%b exp=1", rx_valid); end
    n_checks++; if (rx_data !== 8'h11) begin n_fail++; $display("FAIL ovr_data got=%h exp=11", rx_data); end
    n_checks++; if (ov_cnt !== 1) begin n_fail++; $display("FAIL ovr_pulses got=%0d exp=1", ov_cnt); end
    rx_ready = 1;
    wait_clk(1);
    rx_ready = 0;
    wait_clk(1);
    n_checks++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL ovr_accept got=%b exp=0", rx_valid); end
    n_checks++; if (got_q.size() !== 1 || got_q[0] !== 8'h11) begin n_fail++; $display("FAIL ovr_taken got_n=%0d exp=1", got_q.size()); end
  endtask

  task automatic test_reset_midframe();
    logic [7:0] d;
    clear_obs();
    rx_ready = 0;
    send_frame(8'h5A, 1, 0);
    wait_clk(10);
    d = 8'hF0;
    serial_in = 0;
    wait_clk(BIT);
    for (int i = 0; i < 4; i++) begin
      serial_in = d[i];
      wait_clk(BIT);
    end
    serial_in = d[4];
    wait_clk(BIT / 2);
    n_checks++; if (busy !== 1'b1 || rx_valid !== 1'b1) begin n_fail++; $display("FAIL rstmid_pre busy=%b valid=%b exp=1,1", busy, rx_valid); end
    rst = 1;
    #1;
    n_checks++; if (rx_valid !== 1'b0 || rx_data !== 8'h00 || busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_clear valid=%b data=%h busy=%b exp=0,00,0", rx_valid, rx_data, busy); end
    wait_clk(3);
    rst = 0;
    serial_in = 1;
    wait_clk(5 * BIT);
    clear_obs();
    rx_ready = 1;
    send_frame(8'h0F, 1, 0);
    wait_clk(20);
    n_checks++; if (got_q.size() !== 1 || got_q[0] !== 8'h0F) begin n_fail++; $display("FAIL rstmid_next got_n=%0d exp=1 byte 0f", got_q.size()); end
    n_checks++; if (fe_cnt !== 0) begin n_fail++; $display("FAIL rstmid_ferr got=%0d exp=0", fe_cnt); end
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity();
    clear_obs();
    rx_ready = 1;
    send_frame(8'h07, 1, 0);
    wait_clk(20);
    n_checks++; if (got_q.size() !== 1 || got_q[0] !== 8'h07) begin n_fail++; $display("FAIL par_good got_n=%0d exp=1 byte 07", got_q.size()); end
    send_frame(8'h07, 1, 1);
    wait_clk(20);
    n_checks++; if (fe_cnt !== 1) begin n_fail++; $display("FAIL par_bad_ferr got=%0d exp=1", fe_cnt); end
    n_checks++; if (got_q.size() !== 1) begin n_fail++; $display("FAIL par_bad_drop got=%0d exp=1", got_q.size()); end
  endtask
`endif

  task automatic test_random();
    logic [7:0] exp_q[$];
    int exp_fe;
    logic [7:0] d;
    bit stop, flip;
    clear_obs();
    rx_ready = 1;
    exp_fe = 0;
    for (int n = 0; n < 12; n++) begin
      d = 8'($urandom);
      stop = $urandom_range(0, 3) != 0;
`ifdef UART_RX_PARITY_EN
      flip = $urandom_range(0, 3) == 0;
`else
      flip = 0;
`endif
      send_frame(d, stop, flip);
      serial_in = 1;
      wait_clk(40);
      if (stop && !flip) exp_q.push_back(d);
      else exp_fe++;
    end
    wait_clk(20);
    n_checks++; if (got_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL rnd_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_checks++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL rnd_byte%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
    end
    n_checks++; if (fe_cnt !== exp_fe) begin n_fail++; $display("FAIL rnd_ferr got=%0d exp=%0d", fe_cnt, exp_fe); end
    n_checks++; if (ov_cnt !== 0) begin n_fail++; $display("FAIL rnd_ovr got=%0d exp=0", ov_cnt); end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_false_start();
    test_break();
    test_overrun();
    test_reset_midframe();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
